// File: rtl/decoder_stream_pkg.sv
// Shared types, constants and the line-decode function for decoder_stream.
package decoder_stream_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT   = 2'b00,
    DEC_THERM    = 2'b01,
    DEC_ONEHOT_N = 2'b10,
    DEC_RSVD     = 2'b11
  } dec_mode_e;

  localparam int ERR_CNT_W = 16;

  // Widest code is 8 bits, so at most 256 lines ever exist.
  localparam int MAX_CODE_W = 8;
  localparam int MAX_LINES  = 256;

  // Decode one code into a MAX_LINES-wide vector; only the low n_lines bits
  // are meaningful, the rest are always 0. An out-of-range code yields all 0
  // lines except in ONEHOT_N, where every valid line is 1.
  function automatic logic [MAX_LINES-1:0] dec_lines(
    input logic [MAX_CODE_W-1:0] code,
    input dec_mode_e             mode,
    input int                    n_lines
  );
    logic [MAX_LINES-1:0] l;
    int c;
    bit oor;
    c   = int'(code);
    oor = (c >= n_lines);
    l   = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (i < n_lines) begin
        if (oor) begin
          l[i] = (mode == DEC_ONEHOT_N);
        end else begin
          case (mode)
            DEC_THERM:    l[i] = (i <= c);
            DEC_ONEHOT_N: l[i] = (i != c);
            default:      l[i] = (i == c);  // ONEHOT and the reserved encoding
          endcase
        end
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/decoder_stream_fifo.sv
// Synchronous FIFO holding decoded {err, lines} entries. Read data is the
// registered head, forced to 0 while empty so the output never shows stale data.
module decoder_stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 count;
  logic                        push_ok;
  logic                        pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); occupancy tracks both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Flow-controlled binary decoder: decodes each accepted code, queues the result
// with its out-of-range flag, and keeps a saturating count of bad codes.
module decoder_stream
  import decoder_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_LINES = 8,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_code,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_LINES-1:0] out_lines,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  logic                 run;       // low during reset and the cycle it is held
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 pop;
  logic [MAX_LINES-1:0] dec_full;
  logic [OUT_LINES-1:0] dec;
  logic                 dec_err;
  logic [OUT_LINES:0]   head;

  // Ready is qualified by a registered run flag so reset never reaches
  // in_ready combinationally, yet it reads 0 throughout reset.
  always_ff @(posedge clk) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  assign in_ready  = run && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  assign dec_full = dec_lines(MAX_CODE_W'(in_code), dec_mode_e'(in_mode), OUT_LINES);
  assign dec      = dec_full[OUT_LINES-1:0];
  assign dec_err  = (32'(in_code) >= 32'(OUT_LINES));

  generate
    if (OUT_LINES < MAX_LINES) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^dec_full[MAX_LINES-1:OUT_LINES];
    end
  endgenerate

  decoder_stream_fifo #(
    .WIDTH (OUT_LINES + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata ({dec_err, dec}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_err   = head[OUT_LINES];
  assign out_lines = head[OUT_LINES-1:0];

  // Saturating error counter; clear beats a same-cycle erroneous accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (accept && dec_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_stream.sv
// Directed bench for decoder_stream with a queue scoreboard of expected entries.
module tb_decoder_stream;

  localparam int IW = 3;
  localparam int OL = 5;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_code;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [OL-1:0] out_lines;
  logic          out_err;
  logic [15:0]   err_count;
  logic          err_clr;

  int checks = 0;
  int errors = 0;

  logic [OL:0] q[$];   // expected {err, lines} in FIFO order
  logic [15:0] m_cnt;
  bit          m_rdy;

  always #5 clk = ~clk;

  decoder_stream #(.IN_WIDTH(IW), .OUT_LINES(OL), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lines (out_lines),
    .out_err   (out_err),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the mode table directly.
  function automatic logic [OL:0] ref_dec(input int code, input int mode);
    logic [OL-1:0] l;
    l = '0;
    if (code >= OL) begin
      if (mode == 2) l = '1;
      return {1'b1, l};
    end
    for (int i = 0; i < OL; i++) begin
      if (mode == 1)      l[i] = (i <= code);
      else if (mode == 2) l[i] = (i != code);
      else                l[i] = (i == code);
    end
    return {1'b0, l};
  endfunction

  // One clock: check outputs against the model at negedge, then advance model.
  task automatic step();
    logic        acc;
    logic        pp;
    logic [OL:0] hd;
    @(negedge clk);
    chk("in_ready", in_ready, m_rdy && (q.size() < DP));
    chk("out_valid", out_valid, q.size() != 0);
    hd = (q.size() != 0) ? q[0] : '0;
    chk("out_lines", out_lines, hd[OL-1:0]);
    chk("out_err", out_err, hd[OL]);
    chk("err_count", err_count, m_cnt);
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_cnt = '0;
      m_rdy = 1'b0;
    end else begin
      if (pp && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        hd = ref_dec(int'(in_code), int'(in_mode));
        q.push_back(hd);
        if (err_clr) m_cnt = '0;
        else if (hd[OL] && m_cnt != 16'hFFFF) m_cnt++;
      end else if (err_clr) begin
        m_cnt = '0;
      end
      m_rdy = 1'b1;
    end
    #1;
  endtask

  // Push one code with out_ready low, check the stored head, then drain it.
  task automatic one(input int code, input int mode, input logic [OL-1:0] exp_l,
                     input logic exp_e, input string tag);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = IW'(code);
    in_mode   = 2'(mode);
    step();
    in_valid = 1'b0;
    chk(tag, out_lines, exp_l);
    chk({tag, "_err"}, out_err, exp_e);
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_code = '0; in_mode = '0;
    m_cnt = '0; m_rdy = 1'b0;
    @(posedge clk); #1;
    step();                 // reset state
    rst = 1'b1;
    step();

    // Stream all codes in ONEHOT at full rate; 5..7 are out of range.
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b00;
    for (int c = 0; c < 8; c++) begin
      in_code = IW'(c);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("stream_errs", err_count, 16'd3);
    err_clr = 1'b1; step(); err_clr = 1'b0; step();

    // Modes
    one(3, 1, 5'h0F, 1'b0, "therm3");
    one(3, 2, 5'h17, 1'b0, "onehot_n3");
    one(3, 3, 5'h08, 1'b0, "rsvd3");
    one(0, 1, 5'h01, 1'b0, "therm0");
    one(4, 2, 5'h0F, 1'b0, "onehot_n4");

    // Out of range, then out of range with a same-cycle clear
    one(6, 0, 5'h00, 1'b1, "oor6");
    chk("oor_cnt1", err_count, 16'd1);
    one(7, 2, 5'h1F, 1'b1, "oor7_n");
    chk("oor_cnt2", err_count, 16'd2);
    err_clr = 1'b1;
    one(6, 1, 5'h00, 1'b1, "oor6_clr");
    err_clr = 1'b0;
    chk("oor_clr", err_count, 16'd0);

    // Backpressure: fill, hold off a third code, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00;
    in_code = 3'd1; step();
    in_code = 3'd2; step();
    chk("full_ready", in_ready, 1'b0);
    in_code = 3'd4;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    repeat (3) step();

    // Reset with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1;
    in_code = 3'd2; step();
    in_code = 3'd6; step();
    in_valid = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_lines", out_lines, 5'h00);
    chk("rst_cnt", err_count, 16'd0);
    out_ready = 1'b1;
    repeat (3) step();

    // Saturation
    in_valid = 1'b1; in_code = 3'd7; in_mode = 2'b00;
    repeat (65540) step();
    chk("sat", err_count, 16'hFFFF);
    in_valid = 1'b0;
    repeat (3) step();
    err_clr = 1'b1; step(); err_clr = 1'b0; step();
    chk("sat_clr", err_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
